light_mode_controller: RTL and testbench

Front-panel control and output-select stage around the two programmable blinkers. It debounces the three raw pushbuttons (mode, left, right) against the beat32 tick and steps a four-state light-mode machine. It routes single-cycle shift pulses to whichever blinker is active, and drives the final lamp signal from the selected source. It sits upstream of both blinkers' shift_left/shift_right inputs and downstream of their out pins, replacing the stand-alone mux.

---
 rtl/light_mode_controller_pkg.sv | 27 ++
 rtl/light_mode_controller_button_debouncer.sv | 71 +++++++
 rtl/light_mode_controller.sv | 118 +++++++++++
 tb/tb_light_mode_controller.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/light_mode_controller_pkg.sv
// light_mode_controller_pkg
// Shared light-mode encoding and the mode-advance helper. The mode values are
// also what the blinker-side logic decodes, so they must stay fixed:
// OFF=0, ON=1, FLASH_1=2, FLASH_2=3.
package light_mode_controller_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_FLASH_1 = 2'd2,
    MODE_FLASH_2 = 2'd3
  } light_mode_e;

  // Mode button cycles OFF -> ON -> FLASH_1 -> FLASH_2 -> OFF.
  function automatic light_mode_e next_mode(input light_mode_e cur);
    light_mode_e nxt;
    case (cur)
      MODE_OFF:     nxt = MODE_ON;
      MODE_ON:      nxt = MODE_FLASH_1;
      MODE_FLASH_1: nxt = MODE_FLASH_2;
      MODE_FLASH_2: nxt = MODE_OFF;
      default:      nxt = MODE_OFF;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/light_mode_controller_button_debouncer.sv
// button_debouncer
// Two-flop synchronizer, tick-qualified debounce counter and press detector
// for one raw pushbutton.
// Ports:
//   clk        system clock
//   reset      synchronous active-low reset
//   count_en   debounce tick (one-cycle pulse)
//   btn_raw    asynchronous raw button level, active-high
//   btn_event  one-cycle pulse in the cycle after the debounced level rises
module button_debouncer #(
  parameter int unsigned DEBOUNCE_TICKS = 20,
  parameter int unsigned CNT_W          = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  input  logic btn_raw,
  output logic btn_event
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic             stable_prev_q, stable_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state for synchronizer, counter and debounced level.
  always_comb begin
    sync1_d       = btn_raw;
    sync2_d       = sync1_q;
    stable_d      = stable_q;
    stable_prev_d = stable_q;
    cnt_d         = cnt_q;
    if (sync2_q == stable_q) begin
      // Any cycle of agreement (a bounce) restarts the count, tick or not.
      cnt_d = {CNT_W{1'b0}};
    end else if (count_en) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        cnt_d    = {CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      cnt_q         <= {CNT_W{1'b0}};
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      cnt_q         <= cnt_d;
    end
  end

  // Press only; releases never generate an event. Driven purely from flops.
  assign btn_event = stable_q & ~stable_prev_q;

endmodule

// File: rtl/light_mode_controller.sv
// light_mode_controller
// Front-panel stage: debounces mode/left/right buttons, steps the light mode,
// routes shift pulses to the active blinker and drives the lamp.
// Ports:
//   clk, reset                     clock, synchronous active-low reset
//   count_en                       beat32 debounce tick
//   btn_mode, btn_left, btn_right  raw async buttons, active-high
//   flash_1, flash_2               blinker outputs
//   shift_left_1/right_1           one-cycle shift pulses to blinker 1
//   shift_left_2/right_2           one-cycle shift pulses to blinker 2
//   mode                           current mode register
//   light_out                      registered lamp drive
module light_mode_controller
  import light_mode_controller_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 20,
  parameter int unsigned CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       count_en,
  input  logic       btn_mode,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       flash_1,
  input  logic       flash_2,
  output logic       shift_left_1,
  output logic       shift_right_1,
  output logic       shift_left_2,
  output logic       shift_right_2,
  output logic [1:0] mode,
  output logic       light_out
);

  logic ev_mode_s, ev_left_s, ev_right_s;
  logic left_only_s, right_only_s;

  light_mode_e mode_q, mode_d;
  logic        sl1_q, sl1_d, sr1_q, sr1_d;
  logic        sl2_q, sl2_d, sr2_q, sr2_d;
  logic        light_q, light_d;

  button_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .CNT_W(CNT_W)) u_db_mode (
    .clk(clk), .reset(reset), .count_en(count_en), .btn_raw(btn_mode), .btn_event(ev_mode_s)
  );
  button_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .CNT_W(CNT_W)) u_db_left (
    .clk(clk), .reset(reset), .count_en(count_en), .btn_raw(btn_left), .btn_event(ev_left_s)
  );
  button_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .CNT_W(CNT_W)) u_db_right (
    .clk(clk), .reset(reset), .count_en(count_en), .btn_raw(btn_right), .btn_event(ev_right_s)
  );

  // Simultaneous left+right is ambiguous, so both are dropped.
  assign left_only_s  = ev_left_s & ~ev_right_s;
  assign right_only_s = ev_right_s & ~ev_left_s;

  // Mode advance, shift routing (by pre-transition mode) and lamp select.
  always_comb begin
    mode_d  = mode_q;
    sl1_d   = 1'b0;
    sr1_d   = 1'b0;
    sl2_d   = 1'b0;
    sr2_d   = 1'b0;
    light_d = 1'b0;
    if (ev_mode_s) begin
      mode_d = next_mode(mode_q);
    end else begin
      mode_d = mode_q;
    end
    case (mode_q)
      MODE_FLASH_1: begin
        sl1_d = left_only_s;
        sr1_d = right_only_s;
      end
      MODE_FLASH_2: begin
        sl2_d = left_only_s;
        sr2_d = right_only_s;
      end
      default: begin
        // OFF/ON: shift requests are discarded, not queued.
      end
    endcase
    case (mode_q)
      MODE_OFF:     light_d = 1'b0;
      MODE_ON:      light_d = 1'b1;
      MODE_FLASH_1: light_d = flash_1;
      MODE_FLASH_2: light_d = flash_2;
      default:      light_d = 1'b0;
    endcase
  end

  // Output and mode registers; reset overrides any same-cycle event.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_q  <= MODE_OFF;
      sl1_q   <= 1'b0;
      sr1_q   <= 1'b0;
      sl2_q   <= 1'b0;
      sr2_q   <= 1'b0;
      light_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      sl1_q   <= sl1_d;
      sr1_q   <= sr1_d;
      sl2_q   <= sl2_d;
      sr2_q   <= sr2_d;
      light_q <= light_d;
    end
  end

  assign mode          = mode_q;
  assign shift_left_1  = sl1_q;
  assign shift_right_1 = sr1_q;
  assign shift_left_2  = sl2_q;
  assign shift_right_2 = sr2_q;
  assign light_out     = light_q;

endmodule

// File: tb/tb_light_mode_controller.sv
// tb_light_mode_controller
// Directed bench for light_mode_controller with DEBOUNCE_TICKS=4 and
// count_en high every second cycle.
module tb_light_mode_controller;

  logic       clk;
  logic       reset;
  logic       count_en;
  logic       btn_mode, btn_left, btn_right;
  logic       flash_1, flash_2;
  logic       shift_left_1, shift_right_1, shift_left_2, shift_right_2;
  logic [1:0] mode;
  logic       light_out;

  int checks = 0;
  int errors = 0;

  // Pulse-cycle counters and snapshots.
  int n_sl1 = 0, n_sr1 = 0, n_sl2 = 0, n_sr2 = 0;
  int b_sl1, b_sr1, b_sl2, b_sr2;

  light_mode_controller #(.DEBOUNCE_TICKS(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .count_en(count_en),
    .btn_mode(btn_mode), .btn_left(btn_left), .btn_right(btn_right),
    .flash_1(flash_1), .flash_2(flash_2),
    .shift_left_1(shift_left_1), .shift_right_1(shift_right_1),
    .shift_left_2(shift_left_2), .shift_right_2(shift_right_2),
    .mode(mode), .light_out(light_out)
  );

  always #5 clk = ~clk;

  // Count high cycles of every shift output.
  always @(posedge clk) begin
    if (shift_left_1)  n_sl1 <= n_sl1 + 1;
    if (shift_right_1) n_sr1 <= n_sr1 + 1;
    if (shift_left_2)  n_sl2 <= n_sl2 + 1;
    if (shift_right_2) n_sr2 <= n_sr2 + 1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    count_en = ~count_en;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic snap();
    b_sl1 = n_sl1; b_sr1 = n_sr1; b_sl2 = n_sl2; b_sr2 = n_sr2;
  endtask

  task automatic check_pulses(input string tag, input int e1l, input int e1r,
                              input int e2l, input int e2r);
    check({tag, "_sl1"}, n_sl1 - b_sl1, e1l);
    check({tag, "_sr1"}, n_sr1 - b_sr1, e1r);
    check({tag, "_sl2"}, n_sl2 - b_sl2, e2l);
    check({tag, "_sr2"}, n_sr2 - b_sr2, e2r);
  endtask

  // Bounded wait for mode to reach exp; returns in the first cycle it shows.
  task automatic wait_mode(input string tag, input int exp, input int budget);
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (int'(mode) == exp) break;
    end
    check(tag, int'(mode), exp);
  endtask

  task automatic press_mode(input string tag, input int exp_mode,
                            input int old_light, input int new_light);
    btn_mode = 1'b1;
    wait_mode({tag, "_mode"}, exp_mode, 40);
    check({tag, "_light_lag"}, int'(light_out), old_light);
    cyc();
    check({tag, "_light_new"}, int'(light_out), new_light);
    repeat (20) cyc();
    btn_mode = 1'b0;
    repeat (25) cyc();
  endtask

  initial begin
    clk = 1'b0; reset = 1'b0; count_en = 1'b0;
    btn_mode = 1'b1; btn_left = 1'b1; btn_right = 1'b1;
    flash_1 = 1'b0; flash_2 = 1'b1;

    // Reset held 3 cycles with all buttons pressed.
    repeat (3) cyc();
    check("rst_mode", int'(mode), 0);
    check("rst_light", int'(light_out), 0);
    check("rst_sl1", int'(shift_left_1), 0);
    check("rst_sr1", int'(shift_right_1), 0);
    check("rst_sl2", int'(shift_left_2), 0);
    check("rst_sr2", int'(shift_right_2), 0);
    snap();
    reset = 1'b1;
    // 2 sync cycles + 4 ticks (every 2nd cycle) + event + register.
    repeat (9) cyc();
    check("held_mode_early", int'(mode), 0);
    repeat (2) cyc();
    check("held_mode_after", int'(mode), 1);
    btn_mode = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    repeat (30) cyc();
    check_pulses("held_lr", 0, 0, 0, 0);
    check("on_light", int'(light_out), 1);

    // ON -> FLASH_1 (flash_1=0).
    press_mode("m1to2", 2, 1, 0);

    // Bounce on left in FLASH_1, then a steady hold.
    snap();
    for (int i = 0; i < 10; i++) begin
      btn_left = ~btn_left;
      repeat (3) cyc();
    end
    btn_left = 1'b1;
    repeat (40) cyc();
    check_pulses("bounce", 1, 0, 0, 0);
    btn_left = 1'b0;
    repeat (25) cyc();

    // Mode and right together in FLASH_1: shift routed by old mode.
    snap();
    btn_mode = 1'b1; btn_right = 1'b1;
    wait_mode("mr_mode", 3, 40);
    check("mr_sr1_same_cycle", int'(shift_right_1), 1);
    cyc();
    check("mr_sr1_one_wide", int'(shift_right_1), 0);
    check("mr_light_flash2", int'(light_out), 1);
    repeat (20) cyc();
    btn_mode = 1'b0; btn_right = 1'b0;
    repeat (25) cyc();
    check_pulses("mr", 0, 1, 0, 0);

    // FLASH_2: left+right together discarded, left alone routed.
    snap();
    btn_left = 1'b1; btn_right = 1'b1;
    repeat (30) cyc();
    btn_left = 1'b0; btn_right = 1'b0;
    repeat (25) cyc();
    check_pulses("lr_both", 0, 0, 0, 0);
    snap();
    btn_left = 1'b1;
    repeat (30) cyc();
    btn_left = 1'b0;
    repeat (25) cyc();
    check_pulses("f2_left", 0, 0, 1, 0);

    // FLASH_2 -> OFF -> ON.
    press_mode("m3to0", 0, 1, 0);
    press_mode("m0to1", 1, 0, 1);

    // ON: right press discarded.
    snap();
    btn_right = 1'b1;
    repeat (30) cyc();
    btn_right = 1'b0;
    repeat (25) cyc();
    check_pulses("on_right", 0, 0, 0, 0);
    check("on_right_mode", int'(mode), 1);

    // ON -> FLASH_1, then flash_1 passes through one cycle late.
    press_mode("m1to2b", 2, 1, 0);
    flash_1 = 1'b1;
    cyc();
    check("f1_follow", int'(light_out), 1);

    // Reset mid-debounce (right counter ~2) in FLASH_1.
    snap();
    btn_right = 1'b1;
    repeat (6) cyc();
    reset = 1'b0;
    btn_right = 1'b0;
    cyc();
    reset = 1'b1;
    check("mid_rst_mode", int'(mode), 0);
    check("mid_rst_light", int'(light_out), 0);
    check("mid_rst_sr1", int'(shift_right_1), 0);
    repeat (30) cyc();
    check_pulses("mid_rst_late", 0, 0, 0, 0);
    check("mid_rst_mode_after", int'(mode), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
